lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Two-port arbiter and sequencer in front of a single 16-entry, 11-bit LIFO stack. It shares the stack between two requesters using round-robin arbitration with a valid/ready handshake. It issues at most one push or pop strobe per cycle and tracks occupancy, full and empty. It also provides a flush sequence that drains the stack. The block sits between client logic and the stack storage; the stack itself holds no bounds checking.

## Interface
- DW, 11, data width
- DEPTH, 16, stack capacity in entries
- CW, 5, occupancy counter width; must hold the value DEPTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_op / req1_op  in  1  1 = push, 0 = pop
- req0_data / req1_data  in  DW  push data
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_data / rsp1_data  out  DW  popped data; 0 for push or error
- rsp0_err / rsp1_err  out  1  overflow (push when full) or underflow (pop when empty)
- flush  in  1  single-cycle pulse; drains the stack
- busy  out  1  high while flushing
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_wdata  out  DW  push data to stack
- stk_rdata  in  DW  current top-of-stack from stack (combinational)
- count  out  CW  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- States: IDLE and FLUSH.
- IDLE arbitration:
  - A single requester with valid=1 is granted.
  - When both are valid, grant goes to the requester not granted last. The pointer `last` updates only on an accepted request.
  - readyN = grantN in IDLE; both readies are 0 in FLUSH.
  - Requesters hold valid, op and data stable until ready.
- Accepted push, not full: stk_push=1, stk_wdata=reqN_data, count+1.
- Accepted push, full: no strobe, count unchanged, response err=1.
- Accepted pop, not empty: stk_pop=1, stk_rdata captured into the response register, count-1.
- Accepted pop, empty: no strobe, response data=0, err=1.
- stk_push and stk_pop are never high together. They are never high in a cycle without an accept, except during FLUSH.
- flush in IDLE:
  - It is sampled at the rising edge.
  - It has priority over requests: no grant in that cycle.
  - Go to FLUSH if count>0; otherwise it is ignored.
- flush while in FLUSH: ignored.
- FLUSH:
  - stk_pop=1 and count-1 every cycle.
  - Return to IDLE on the cycle the pop takes count to 0.
  - No responses are generated.
- Arithmetic: count never wraps. Saturation cases are turned into errors as listed above.

## Timing
- Reset values:
  - State IDLE, count=0, empty=1, full=0, busy=0.
  - All ready, rsp*_valid, rsp*_data, rsp*_err, stk_push and stk_pop are 0; stk_wdata=0.
  - last=1, so requester 0 wins the first contention.
- ready, stk_push, stk_pop and stk_wdata are combinational in the accept cycle.
- Response latency is 1 cycle: rspN_valid/data/err are registered and valid in cycle T+1 for an accept in T, for exactly one cycle.
- Throughput is one accepted request per cycle. Back-to-back pushes and pops are legal, and pop-after-push returns the just-pushed value.
- count, full and empty are registered and reflect all accepts up to the previous edge.
- Flush of N entries:
  - busy=1 and stk_pop=1 for N cycles, starting the cycle after flush is sampled.
  - count reaches 0 and busy falls at the edge ending the Nth pop.
- Reset asserted mid-FLUSH or mid-response returns every register to its reset value on that edge. No strobe is driven in the reset cycle.
- A response pending from T is still delivered in T+1, even if flush is sampled in T+1.

## Test plan
- Reset then idle: all outputs at reset values; empty=1, count=0.
- Requester 0 pushes 0x101, 0x202, 0x303, then pops three times -> rsp0_data 0x303, 0x202, 0x101 on successive cycles, err=0, count ends at 0.
- Both requesters valid every cycle with pushes 0x0AA (req0) and 0x055 (req1) -> grants alternate 0,1,0,1 from reset; stack order matches grant order; count increments by 1 per cycle.
- Push 16 values, then a 17th push -> rsp err=1, no stk_push, count=16, full=1. Then pop from empty after draining -> err=1, data=0.
- With count=5, pulse flush while req1 is valid -> req1_ready=0 for the flush cycle and 5 busy cycles; exactly 5 stk_pop pulses; count=0; req1 is then accepted.
- Assert rst during cycle 3 of a 10-entry flush -> next cycle count=0, busy=0, stk_pop=0, state IDLE.

Source files
------------

// File: rtl/lifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lifo_arbiter                                               |
// | Description : Round-robin two-port arbiter/sequencer for a LIFO stack    |
// |               with occupancy tracking and a flush (drain) sequence.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lifo_arbiter #(
  parameter int DW    = 11,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_op,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_op,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_err,
  input  logic          flush,
  output logic          busy,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [0:0]    c_IDLE  = 1'b0;
  localparam logic [0:0]    c_FLUSH = 1'b1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_last;
  logic [CW-1:0] r_count;
  logic          r_rsp0_valid, r_rsp1_valid;
  logic          r_rsp0_err, r_rsp1_err;
  logic [DW-1:0] r_rsp0_data, r_rsp1_data;

  logic          w_full, w_empty, w_arb_en;
  logic          w_grant0, w_grant1, w_acc, w_op;
  logic [DW-1:0] w_data;
  logic          w_push, w_pop, w_rsp_err;
  logic [DW-1:0] w_rsp_data;

  assign w_full   = (r_count == c_DEPTH);
  assign w_empty  = (r_count == '0);
  // flush outranks requests, and nothing is granted while reset is held
  assign w_arb_en = !rst && (r_state == c_IDLE) && !flush;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (flush && !w_empty) w_state_nxt = c_FLUSH;
      c_FLUSH: if (r_count == c_ONE)  w_state_nxt = c_IDLE;
    endcase
  end

  // output / grant logic
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_arb_en) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last;
        w_grant1 = !r_last;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
    w_acc      = w_grant0 | w_grant1;
    w_op       = w_grant0 ? req0_op   : req1_op;
    w_data     = w_grant0 ? req0_data : req1_data;
    w_push     = w_acc && w_op && !w_full;
    w_pop      = (w_acc && !w_op && !w_empty) || (!rst && (r_state == c_FLUSH));
    w_rsp_err  = w_op ? w_full : w_empty;
    w_rsp_data = (!w_op && !w_empty) ? stk_rdata : '0;
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign stk_push   = w_push;
  assign stk_pop    = w_pop;
  assign stk_wdata  = w_push ? w_data : '0;
  assign busy       = (r_state == c_FLUSH);
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp0_err   = r_rsp0_err;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_data  = r_rsp1_data;
  assign rsp1_err   = r_rsp1_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_count      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_err   <= 1'b0;
    end else begin
      if (w_acc) r_last <= w_grant1;
      if (w_push)     r_count <= r_count + c_ONE;
      else if (w_pop) r_count <= r_count - c_ONE;
      r_rsp0_valid <= w_grant0;
      r_rsp0_data  <= w_grant0 ? w_rsp_data : '0;
      r_rsp0_err   <= w_grant0 && w_rsp_err;
      r_rsp1_valid <= w_grant1;
      r_rsp1_data  <= w_grant1 ? w_rsp_data : '0;
      r_rsp1_err   <= w_grant1 && w_rsp_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lifo_arbiter                                            |
// | Description : Directed bench for lifo_arbiter with a small stack model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lifo_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_op, req1_valid, req1_op, flush;
  logic [10:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [10:0] rsp0_data, rsp1_data;
  logic        busy, stk_push, stk_pop, full, empty;
  logic [10:0] stk_wdata, stk_rdata;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  int pop_pulses = 0;

  always #5 clk = ~clk;

  lifo_arbiter #(.DW(11), .DEPTH(16), .CW(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .flush(flush), .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  // stack storage model
  logic [10:0] mem [0:15];
  logic [4:0]  sp;
  logic [3:0]  top;
  assign top       = 4'(sp - 5'd1);
  assign stk_rdata = (sp != 5'd0) ? mem[top] : 11'h0;

  always @(posedge clk) begin
    if (rst) begin
      sp <= 5'd0;
    end else if (stk_push && sp < 5'd16) begin
      mem[sp[3:0]] <= stk_wdata;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp != 5'd0) begin
      sp <= sp - 5'd1;
    end
    if (stk_pop) pop_pulses <= pop_pulses + 1;
  end

  typedef struct {
    logic        rst;
    logic        v0, op0;
    logic [10:0] d0;
    logic        v1, op1;
    logic [10:0] d1;
    logic [1:0]  rdy;   // {ready1, ready0}
    logic        psh, pop;
    logic [10:0] wd;
    logic [1:0]  rv;    // {rsp1_valid, rsp0_valid}
    logic [10:0] rd0, rd1;
    logic [1:0]  err;   // {rsp1_err, rsp0_err}
    logic [4:0]  cnt;
    logic        busy;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic o0, input logic [10:0] dd0,
                       input logic v1, input logic o1, input logic [10:0] dd1, input logic fl);
    @(negedge clk);
    rst = r; flush = fl;
    req0_valid = v0; req0_op = o0; req0_data = dd0;
    req1_valid = v1; req1_op = o1; req1_data = dd1;
    #1;
  endtask

  logic [48:0] obs, expv;
  int base;

  initial begin
    // rst v0 op0 d0 v1 op1 d1 | rdy psh pop wd rv rd0 rd1 err cnt busy
    tbl[0]  = '{0,1,1,11'h101,0,0,11'h0, 2'b01,1,0,11'h101, 2'b00,11'h0,  11'h0,  2'b00,5'd0,0};
    tbl[1]  = '{0,1,1,11'h202,0,0,11'h0, 2'b01,1,0,11'h202, 2'b01,11'h0,  11'h0,  2'b00,5'd1,0};
    tbl[2]  = '{0,1,1,11'h303,0,0,11'h0, 2'b01,1,0,11'h303, 2'b01,11'h0,  11'h0,  2'b00,5'd2,0};
    tbl[3]  = '{0,1,0,11'h0,  0,0,11'h0, 2'b01,0,1,11'h0,   2'b01,11'h0,  11'h0,  2'b00,5'd3,0};
    tbl[4]  = '{0,1,0,11'h0,  0,0,11'h0, 2'b01,0,1,11'h0,   2'b01,11'h303,11'h0,  2'b00,5'd2,0};
    tbl[5]  = '{0,1,0,11'h0,  0,0,11'h0, 2'b01,0,1,11'h0,   2'b01,11'h202,11'h0,  2'b00,5'd1,0};
    tbl[6]  = '{0,0,0,11'h0,  0,0,11'h0, 2'b00,0,0,11'h0,   2'b01,11'h101,11'h0,  2'b00,5'd0,0};
    tbl[7]  = '{1,1,1,11'h0AA,1,1,11'h055,2'b00,0,0,11'h0,  2'b00,11'h0,  11'h0,  2'b00,5'd0,0};
    tbl[8]  = '{0,1,1,11'h0AA,1,1,11'h055,2'b01,1,0,11'h0AA,2'b00,11'h0,  11'h0,  2'b00,5'd0,0};
    tbl[9]  = '{0,1,1,11'h0AA,1,1,11'h055,2'b10,1,0,11'h055,2'b01,11'h0,  11'h0,  2'b00,5'd1,0};
    tbl[10] = '{0,1,1,11'h0AA,1,1,11'h055,2'b01,1,0,11'h0AA,2'b10,11'h0,  11'h0,  2'b00,5'd2,0};
    tbl[11] = '{0,1,1,11'h0AA,1,1,11'h055,2'b10,1,0,11'h055,2'b01,11'h0,  11'h0,  2'b00,5'd3,0};
    tbl[12] = '{0,0,0,11'h0,  1,0,11'h0, 2'b10,0,1,11'h0,   2'b10,11'h0,  11'h0,  2'b00,5'd4,0};
    tbl[13] = '{0,1,0,11'h0,  0,0,11'h0, 2'b01,0,1,11'h0,   2'b10,11'h0,  11'h055,2'b00,5'd3,0};
    tbl[14] = '{0,0,0,11'h0,  0,0,11'h0, 2'b00,0,0,11'h0,   2'b01,11'h0AA,11'h0,  2'b00,5'd2,0};
    tbl[15] = '{1,0,0,11'h0,  0,0,11'h0, 2'b00,0,0,11'h0,   2'b00,11'h0,  11'h0,  2'b00,5'd2,0};

    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0;
    repeat (2) @(posedge clk);

    // reset state
    drive(0,0,0,0,0,0,0,0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_wdata}, 0);
    chk("rst_rsp", {rsp0_valid, rsp0_err, rsp0_data, rsp1_valid, rsp1_err, rsp1_data}, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].op0, tbl[i].d0, tbl[i].v1, tbl[i].op1, tbl[i].d1, 0);
      obs  = {req1_ready, req0_ready, stk_push, stk_pop, stk_wdata, rsp1_valid, rsp0_valid,
              rsp0_data, rsp1_data, rsp1_err, rsp0_err, count, full, empty, busy};
      expv = {tbl[i].rdy, tbl[i].psh, tbl[i].pop, tbl[i].wd, tbl[i].rv, tbl[i].rd0, tbl[i].rd1,
              tbl[i].err, tbl[i].cnt, (tbl[i].cnt == 5'd16), (tbl[i].cnt == 5'd0), tbl[i].busy};
      chk($sformatf("vec%0d", i), obs, expv);
    end

    // fill to capacity, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(0,1,1,11'(i*3+7),0,0,0,0);
      chk("fill_push", stk_push, 1);
      chk("fill_count", count, 64'(i));
    end
    drive(0,1,1,11'h7FF,0,0,0,0);
    chk("ovf_ready", req0_ready, 1);
    chk("ovf_nopush", stk_push, 0);
    chk("ovf_full", {full, count}, {1'b1, 5'd16});
    drive(0,0,0,0,0,0,0,0);
    chk("ovf_rsp", {rsp0_valid, rsp0_err, rsp0_data}, {1'b1, 1'b1, 11'h0});
    chk("ovf_count", count, 16);

    // drain, then underflow
    for (int i = 0; i < 16; i++) begin
      drive(0,1,0,0,0,0,0,0);
      chk("drain_pop", stk_pop, 1);
      if (i > 0) chk("drain_data", {rsp0_valid, rsp0_err, rsp0_data}, {1'b1, 1'b0, 11'((16-i)*3+7)});
    end
    drive(0,1,0,0,0,0,0,0);
    chk("drain_last", rsp0_data, 7);
    chk("udf_nopop", stk_pop, 0);
    chk("udf_empty", {empty, count}, {1'b1, 5'd0});
    drive(0,0,0,0,0,0,0,0);
    chk("udf_rsp", {rsp0_valid, rsp0_err, rsp0_data}, {1'b1, 1'b1, 11'h0});

    // flush on an empty stack is ignored
    drive(0,0,0,0,0,0,0,1);
    drive(0,0,0,0,0,0,0,0);
    chk("flush_empty_busy", busy, 0);

    // flush of 5 entries while req1 waits
    for (int i = 0; i < 5; i++) drive(0,1,1,11'(16+i),0,0,0,0);
    drive(0,0,0,0,1,0,0,1);
    chk("fl_ready1", req1_ready, 0);
    chk("fl_pending_rsp", rsp0_valid, 1);
    chk("fl_nopop", {busy, stk_pop}, 0);
    base = pop_pulses;
    for (int k = 0; k < 5; k++) begin
      drive(0,0,0,0,1,0,0,0);
      chk("fl_busy", {busy, stk_pop, req1_ready}, 3'b110);
      chk("fl_count", count, 64'(5-k));
    end
    drive(0,0,0,0,1,0,0,0);
    chk("fl_done", {busy, count, req1_ready, stk_pop}, {1'b0, 5'd0, 1'b1, 1'b0});
    chk("fl_pulses", 64'(pop_pulses - base), 5);
    drive(0,0,0,0,0,0,0,0);
    chk("fl_after_rsp", {rsp1_valid, rsp1_err, rsp1_data}, {1'b1, 1'b1, 11'h0});

    // reset in the third cycle of a 10-entry flush
    for (int i = 0; i < 10; i++) drive(0,0,0,0,1,1,11'(32+i),0);
    drive(0,0,0,0,0,0,0,1);
    chk("rf_count10", count, 10);
    drive(0,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    chk("rf_busy", {busy, stk_pop}, 2'b11);
    drive(1,0,0,0,0,0,0,0);
    chk("rf_rst_nopop", stk_pop, 0);
    drive(0,0,0,0,0,0,0,0);
    chk("rf_after", {count, busy, stk_pop, empty}, {5'd0, 1'b0, 1'b0, 1'b1});
    drive(0,1,1,11'h123,1,1,11'h321,0);
    chk("rf_idle_grant", {req1_ready, req0_ready, stk_wdata}, {2'b01, 11'h123});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
